// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM port controller.
// Matches the single-port synchronous macro family (512 x 64).
package sram_ctrl_pkg;

    localparam int BITS_DEF  = 64;
    localparam int DEPTH_DEF = 512;
    localparam int AW_DEF    = 9;

    // Controller modes: zero-fill sweep, then normal request service.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of read responses that may be owed at any time.
    localparam int RD_CREDITS = 2;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response buffer holding read data the consumer has not taken.
// Head is forced to zero when empty so stale data never leaks out.
module sram_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int Bits = BITS_DEF
) (
    input  logic            CLK,
    input  logic            RSTB,
    input  logic            push,
    input  logic            pop,
    input  logic [Bits-1:0] wdata,
    output logic [Bits-1:0] head,
    output logic [1:0]      count
);

    logic [Bits-1:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    // Storage, pointers and occupancy; push and pop together keep count.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM macro.
// Optional zero-fill after reset, then zero-cycle request issue.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int Bits       = BITS_DEF,
    parameter int Word_Depth = DEPTH_DEF,
    parameter int Add_Width  = AW_DEF,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RSTB,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [Add_Width-1:0] req_addr,
    input  logic [Bits-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [Bits-1:0]      resp_rdata,
    output logic                 init_done,
    output logic                 sram_CEB,
    output logic                 sram_WEB,
    output logic [Add_Width-1:0] sram_A,
    output logic [Bits-1:0]      sram_D,
    input  logic [Bits-1:0]      sram_Q
);

    localparam logic [Add_Width-1:0] LAST = Add_Width'(Word_Depth - 1);
    localparam state_t RST_STATE = INIT_EN ? INIT : RUN;

    state_t               state;
    state_t               state_nxt;
    logic [Add_Width-1:0] init_cnt;
    logic                 inflight;

    logic                 filling;
    logic                 running;
    logic [2:0]           owed;
    logic                 rd_credit;
    logic                 fire;
    logic                 rd_fire;

    logic [1:0]           fifo_count;
    logic [Bits-1:0]      fifo_head;
    logic                 fifo_nonempty;
    logic                 fifo_push;
    logic                 fifo_pop;

    // Pins follow reset immediately, so mode is qualified with RSTB.
    assign filling = RSTB && (state == INIT);
    assign running = RSTB && (state == RUN);

    // Credit uses registered occupancy only; same-cycle pops don't count.
    assign owed      = 3'(fifo_count) + 3'(inflight);
    assign rd_credit = owed < 3'(RD_CREDITS);

    assign req_ready = running && (req_write || rd_credit);
    assign fire      = req_valid && req_ready;
    assign rd_fire   = fire && !req_write;
    assign init_done = (state == RUN);

    // Mode register, fill address and outstanding-read flag.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= RST_STATE;
            init_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_fire;
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Leave the fill sweep after the last word; RUN is sticky.
    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == LAST) begin
            state_nxt = RUN;
        end
    end

    // Macro pin drive: fill writes, accepted requests, otherwise idle.
    always_comb begin
        sram_CEB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_D   = '0;
        if (filling) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = init_cnt;
        end else if (fire) begin
            sram_CEB = 1'b0;
            sram_WEB = !req_write;
            sram_A   = req_addr;
            sram_D   = req_write ? req_wdata : '0;
        end
    end

    assign fifo_nonempty = (fifo_count != 2'd0);
    assign fifo_push     = inflight && (fifo_nonempty || !resp_ready);
    assign fifo_pop      = fifo_nonempty && resp_ready;

    // Response select: buffered head first, else bypass of the macro output.
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = '0;
        if (fifo_nonempty) begin
            resp_valid = 1'b1;
            resp_rdata = fifo_head;
        end else if (inflight) begin
            resp_valid = 1'b1;
            resp_rdata = sram_Q;
        end
    end

    sram_resp_fifo #(
        .Bits (Bits)
    ) u_fifo (
        .CLK   (CLK),
        .RSTB  (RSTB),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (sram_Q),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule
